// File: rtl/keypad_encoder.sv
// Keypad front end: synchronises and debounces 16 raw key lines and emits one
// single-cycle BPRESS per accepted press, with BUTTON holding the key index.
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] KEY_RAW,
    output logic [3:0]  BUTTON,
    output logic        BPRESS,
    output logic        KEY_HELD,
    output logic        MULTI_ERR
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        FIRE        = 3'd2,
        HELD        = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [15:0]      key_s1;
    logic [15:0]      key_sync;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       cand;
    logic [3:0]       cand_nxt;
    logic [3:0]       button_nxt;
    logic             bpress_nxt;
    logic             held_nxt;
    logic             multi_nxt;

    logic             ks_zero;
    logic             ks_onehot;
    logic             ks_multi;
    logic             ks_match;
    logic [3:0]       ks_index;
    logic [15:0]      cand_mask;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_s1   <= '0;
            key_sync <= '0;
        end else begin
            key_s1   <= KEY_RAW;
            key_sync <= key_s1;
        end
    end

    // A value is one-hot when clearing its lowest set bit leaves nothing behind.
    always_comb begin
        ks_zero   = (key_sync == 16'd0);
        ks_onehot = !ks_zero && ((key_sync & (key_sync - 16'd1)) == 16'd0);
        ks_multi  = !ks_zero && !ks_onehot;
        cand_mask = 16'd1 << cand;
        ks_match  = (key_sync == cand_mask);
        ks_index  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key_sync[i]) begin
                ks_index = 4'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        multi_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (ks_onehot) begin
                    cand_nxt  = ks_index;
                    cnt_nxt   = '0;
                    state_nxt = DEB_PRESS;
                end else if (ks_multi) begin
                    multi_nxt = 1'b1;
                end
            end

            DEB_PRESS: begin
                if (ks_match) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FIRE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end

            FIRE: begin
                state_nxt = HELD;
            end

            HELD: begin
                if (ks_zero) begin
                    cnt_nxt   = '0;
                    state_nxt = DEB_RELEASE;
                end
            end

            // Any key seen while the release settles is bounce, not a new press.
            DEB_RELEASE: begin
                if (ks_zero) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    state_nxt = HELD;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        bpress_nxt = (state_nxt == FIRE);
        held_nxt   = (state_nxt == HELD) || (state_nxt == DEB_RELEASE);
        button_nxt = (state_nxt == FIRE) ? cand_nxt : BUTTON;
    end

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            BUTTON    <= '0;
            BPRESS    <= 1'b0;
            KEY_HELD  <= 1'b0;
            MULTI_ERR <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            BUTTON    <= button_nxt;
            BPRESS    <= bpress_nxt;
            KEY_HELD  <= held_nxt;
            MULTI_ERR <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed scenarios then random press episodes, all
// compared cycle by cycle against a run-length model of the key stream.
module tb_keypad_encoder;

    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] KEY_RAW = 16'd0;
    logic [3:0]  BUTTON;
    logic        BPRESS;
    logic        KEY_HELD;
    logic        MULTI_ERR;

    int tests = 0;
    int fails = 0;

    logic [15:0] hist1, hist2;
    logic        m_armed, m_skip, m_held;
    int          m_run, m_zeros;
    logic [15:0] m_key;
    logic [3:0]  m_button;
    logic        exp_bpress, exp_multi;

    int tick_no, press_cnt, press_edge, multi_seen;

    keypad_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KEY_RAW  (KEY_RAW),
        .BUTTON   (BUTTON),
        .BPRESS   (BPRESS),
        .KEY_HELD (KEY_HELD),
        .MULTI_ERR(MULTI_ERR)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at tick %0d", tag, obs, exp, tick_no);
        end
    endtask

    task automatic model_reset();
        hist1      = '0;
        hist2      = '0;
        m_armed    = 1'b1;
        m_skip     = 1'b0;
        m_held     = 1'b0;
        m_run      = 0;
        m_zeros    = 0;
        m_key      = '0;
        m_button   = '0;
        exp_bpress = 1'b0;
        exp_multi  = 1'b0;
    endtask

    // A press counts once the same single key is seen D+1 samples in a row while
    // released; a release counts once D+1 zero samples follow an accepted press.
    task automatic model_edge(input logic [15:0] raw_now);
        logic [15:0] s;
        s          = hist2;
        hist2      = hist1;
        hist1      = raw_now;
        exp_bpress = 1'b0;
        exp_multi  = 1'b0;
        if (m_skip) begin
            m_skip = 1'b0;
            m_held = 1'b1;
        end else if (!m_armed) begin
            if (s == 16'd0) begin
                m_zeros++;
                if (m_zeros == D + 1) begin
                    m_armed = 1'b1;
                    m_held  = 1'b0;
                    m_run   = 0;
                end
            end else begin
                m_zeros = 0;
            end
        end else begin
            exp_multi = ($countones(s) > 1) && (m_run == 0);
            if ($countones(s) == 1) begin
                if (m_run > 0 && s == m_key) begin
                    m_run++;
                end else begin
                    m_run = 1;
                    m_key = s;
                end
            end else begin
                m_run = 0;
            end
            if (m_run == D + 1) begin
                exp_bpress = 1'b1;
                m_button   = 4'($clog2(m_key));
                m_armed    = 1'b0;
                m_skip     = 1'b1;
                m_zeros    = 0;
                m_run      = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] raw, input int n);
        repeat (n) begin
            KEY_RAW = raw;
            @(posedge CLK);
            tick_no++;
            model_edge(raw);
            #2;
            checkOutput();
        end
    endtask

    task automatic checkOutput();
        check("BPRESS", BPRESS, exp_bpress);
        check("BUTTON", BUTTON, m_button);
        check("KEY_HELD", KEY_HELD, m_held);
        check("MULTI_ERR", MULTI_ERR, exp_multi);
        if (BPRESS) begin
            press_cnt++;
            if (press_edge < 0) press_edge = tick_no;
        end
        if (MULTI_ERR) multi_seen++;
    endtask

    task automatic startPhase();
        tick_no    = 0;
        press_cnt  = 0;
        press_edge = -1;
        multi_seen = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_BPRESS"}, BPRESS, 0);
        check({tag, "_BUTTON"}, BUTTON, 0);
        check({tag, "_KEY_HELD"}, KEY_HELD, 0);
        check({tag, "_MULTI_ERR"}, MULTI_ERR, 0);
    endtask

    task automatic asyncReset();
        #3;
        RST = 1'b1;
        #1;
        checkResetOutputs("RST_ASYNC");
        model_reset();
        @(posedge CLK);
        #2;
        checkResetOutputs("RST_HOLD");
        #3;
        RST = 1'b0;
        startPhase();
    endtask

    initial begin
        int          hold, gap, a, b, h1, g;
        logic [15:0] val;

        model_reset();
        startPhase();
        #2;
        checkResetOutputs("RST_INIT");
        #20;
        RST = 1'b0;
        applyStimulus(16'h0000, 6);

        $display("[TB] scenario 1: clean press of key 8");
        startPhase();
        applyStimulus(16'h0100, 20);
        check("T1_PRESS_EDGE", press_edge, 7);
        check("T1_PRESS_CNT", press_cnt, 1);
        check("T1_BUTTON", BUTTON, 8);
        applyStimulus(16'h0000, 10);

        $display("[TB] scenario 2: bouncing key 3");
        startPhase();
        applyStimulus(16'h0008, 1);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h0008, 1);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h0008, 10);
        check("T2_PRESS_CNT", press_cnt, 1);
        check("T2_BUTTON", BUTTON, 3);
        applyStimulus(16'h0000, 10);

        $display("[TB] scenario 3: chord of keys 1 and 4");
        startPhase();
        applyStimulus(16'h0012, 8);
        check("T3_MULTI_SEEN", multi_seen > 0, 1);
        check("T3_NO_PRESS", press_cnt, 0);
        applyStimulus(16'h0002, 10);
        check("T3_PRESS_CNT", press_cnt, 1);
        check("T3_BUTTON", BUTTON, 1);
        check("T3_MULTI_CLEAR", MULTI_ERR, 0);
        applyStimulus(16'h0000, 10);

        $display("[TB] scenario 4: repeated key 5 with hold glitch");
        startPhase();
        applyStimulus(16'h0020, 10);
        applyStimulus(16'h0000, 10);
        applyStimulus(16'h0020, 10);
        applyStimulus(16'h0000, 2);
        applyStimulus(16'h0020, 6);
        applyStimulus(16'h0000, 10);
        check("T4_PRESS_CNT", press_cnt, 2);
        check("T4_BUTTON", BUTTON, 5);

        $display("[TB] scenario 5: reset during debounce of key 7");
        startPhase();
        applyStimulus(16'h0080, 4);
        check("T5_NO_EARLY_PRESS", press_cnt, 0);
        asyncReset();
        applyStimulus(16'h0080, 12);
        check("T5_PRESS_EDGE", press_edge, 7);
        check("T5_PRESS_CNT", press_cnt, 1);
        check("T5_BUTTON", BUTTON, 7);
        applyStimulus(16'h0000, 10);

        $display("[TB] scenario 6: key 9 added while key 2 held");
        startPhase();
        applyStimulus(16'h0004, 10);
        applyStimulus(16'h0204, 5);
        applyStimulus(16'h0200, 10);
        check("T6_NO_PRESS_9", press_cnt, 1);
        check("T6_BUTTON_2", BUTTON, 2);
        applyStimulus(16'h0000, 10);
        applyStimulus(16'h0200, 10);
        check("T6_PRESS_CNT", press_cnt, 2);
        check("T6_BUTTON_9", BUTTON, 9);
        applyStimulus(16'h0000, 10);

        $display("[TB] random press episodes");
        for (int ep = 0; ep < 80; ep++) begin
            a = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                b   = (a + int'($urandom_range(1, 15))) % 16;
                val = (16'd1 << a) | (16'd1 << b);
            end else begin
                val = 16'd1 << a;
            end
            hold = int'($urandom_range(1, 10));
            gap  = int'($urandom_range(1, 10));
            if (hold >= 4 && $urandom_range(0, 3) == 0) begin
                h1 = int'($urandom_range(1, hold - 1));
                g  = int'($urandom_range(1, 2));
                applyStimulus(val, h1);
                applyStimulus(16'h0000, g);
                applyStimulus(val, hold - h1);
            end else begin
                applyStimulus(val, hold);
            end
            applyStimulus(16'h0000, gap);
        end
        applyStimulus(16'h0000, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
